// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline control slice.
package pipeline_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_load_use_cmp.sv
// Combinational load-use compare between a load in EX and the sources of the ID instruction.
module hazard_load_use_cmp
  import pipeline_pkg::*;
(
  input  logic                  mem_read,
  input  logic [REG_ADDR_W-1:0] load_rd,
  input  logic [REG_ADDR_W-1:0] src_rs,
  input  logic [REG_ADDR_W-1:0] src_rt,
  input  logic                  uses_rt,
  output logic                  hazard
);

  // $zero is never a real dependency.
  assign hazard = mem_read && (load_rd != REG_ZERO) &&
                  ((load_rd == src_rs) || (uses_rt && (load_rd == src_rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register enable/flush sequencing: load-use stall, EX redirect squash, mul/div freeze.
// Optional HAZARD_PERF_CNT_EN adds saturating stall_cycles / flush_events counters.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  ex_redirect,
  input  logic                  ex_md_start,
  input  logic                  ext_stall,
  output logic                  pc_enable,
  output logic                  if_id_enable,
  output logic                  if_id_flush,
  output logic                  id_ex_enable,
  output logic                  id_ex_flush,
  output logic                  ex_mem_enable,
  output logic                  ex_mem_flush,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events,
`endif
  output logic                  md_busy
);

  localparam int unsigned MDC_W = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;

  if (MD_LATENCY < 2) begin : g_bad_latency
    $error("MD_LATENCY must be at least 2");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  state_t           state, state_nx;
  logic [MDC_W-1:0] md_cnt, md_cnt_nx;
  logic             lu;

  hazard_load_use_cmp u_lu_cmp (
    .mem_read (ex_mem_read),
    .load_rd  (ex_rt),
    .src_rs   (id_rs),
    .src_rt   (id_rt),
    .uses_rt  (id_uses_rt),
    .hazard   (lu)
  );

  always_comb begin
    pc_enable     = 1'b1;
    if_id_enable  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_enable  = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_enable = 1'b1;
    ex_mem_flush  = 1'b0;
    state_nx      = state;
    md_cnt_nx     = md_cnt;
    unique case (state)
      RUN: begin
        if (ext_stall) begin
          pc_enable     = 1'b0;
          if_id_enable  = 1'b0;
          id_ex_enable  = 1'b0;
          ex_mem_enable = 1'b0;
        end else if (ex_redirect) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (ex_md_start) begin
          pc_enable    = 1'b0;
          if_id_enable = 1'b0;
          id_ex_enable = 1'b0;
          ex_mem_flush = 1'b1;
          state_nx     = MD_BUSY;
          md_cnt_nx    = MDC_W'(MD_LATENCY - 2);
        end else if (lu) begin
          pc_enable    = 1'b0;
          if_id_enable = 1'b0;
          id_ex_flush  = 1'b1;
        end
      end
      MD_BUSY: begin
        if (md_cnt != '0) begin
          // The unit keeps counting through an external stall.
          md_cnt_nx    = md_cnt - MDC_W'(1);
          pc_enable    = 1'b0;
          if_id_enable = 1'b0;
          id_ex_enable = 1'b0;
          if (ext_stall) begin
            ex_mem_enable = 1'b0;
          end else begin
            ex_mem_flush = 1'b1;
          end
        end else if (ext_stall) begin
          pc_enable     = 1'b0;
          if_id_enable  = 1'b0;
          id_ex_enable  = 1'b0;
          ex_mem_enable = 1'b0;
        end else begin
          state_nx = RUN;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  // md_busy marks the counting cycles only; the release cycle at md_cnt 0 is not busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RUN;
      md_cnt  <= '0;
      md_busy <= 1'b0;
    end else begin
      state   <= state_nx;
      md_cnt  <= md_cnt_nx;
      md_busy <= (state_nx == MD_BUSY) && (md_cnt_nx != '0);
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!pc_enable && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_W'(1);
      if (if_id_flush && (flush_events != '1)) flush_events <= flush_events + CNT_W'(1);
    end
  end
`endif

endmodule
